// File: rtl/mfp_eic_lite_pkg.sv
// Shared definitions for mfp_eic_lite: register offsets, FSM states, AHB data-phase record
// and the IPL-to-vector mapping used when presenting a request to the core.
package mfp_eic_lite_pkg;

    localparam logic [2:0] REG_MASK    = 3'd0;
    localparam logic [2:0] REG_SENSE   = 3'd1;
    localparam logic [2:0] REG_PENDING = 3'd2;
    localparam logic [2:0] REG_CLEAR   = 3'd3;
    localparam logic [2:0] REG_SET     = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       write;
        logic [2:0] addr;
    } dphase_t;

    // Vector number equals the requested IPL; the offset keeps the mapping in one place.
    localparam logic [5:0] IPL_VEC_OFFSET = 6'd0;

    function automatic logic [5:0] ipl_to_vec(input logic [5:0] ipl);
        return ipl + IPL_VEC_OFFSET;
    endfunction

endpackage

// File: rtl/mfp_eic_lite_if.sv
// AHB-Lite slave port bundle for mfp_eic_lite; the master modport belongs to the bus side.
interface mfp_eic_lite_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/mfp_eic_lite_prio.sv
// Combinational fixed-priority encoder: the highest set bit of req_i wins and is reported
// as index+1, so 0 means no request.
module mfp_eic_lite_prio #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [5:0]   idx_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise a path with no
        // request would leave idx_o unassigned and infer a latch.
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = 6'(i + 1);
            end
        end
    end

endmodule

// File: rtl/mfp_eic_lite.sv
// External interrupt controller feeding the MIPS EIC interface, configured over AHB-Lite.
// Build macro MFP_EIC_LITE_CPUINT_EN adds SI_TimerInt/SI_SWInt as level sources above irq.
module mfp_eic_lite
    import mfp_eic_lite_pkg::*;
#(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               HCLK,
    input  logic               HRESET,
    mfp_eic_lite_if.slave      ahb,
    input  logic [NUM_IRQ-1:0] irq,
`ifdef MFP_EIC_LITE_CPUINT_EN
    input  logic               SI_TimerInt,
    input  logic [1:0]         SI_SWInt,
`endif
    output logic [7:0]         SI_Int,
    output logic [5:0]         SI_EICVector,
    output logic               SI_EICPresent,
    output logic [16:0]        SI_Offset,
    output logic [3:0]         SI_EISS,
    input  logic               SI_IAck,
    input  logic [5:0]         SI_IVN,
    input  logic [7:0]         SI_IPL
);

`ifdef MFP_EIC_LITE_CPUINT_EN
    localparam int NUM_CPU = 3;
`else
    localparam int NUM_CPU = 0;
`endif
    localparam int NSRC = NUM_IRQ + NUM_CPU;

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
    logic [NSRC-1:0]    src, src_dly_q, edge_mask;
    logic [NSRC-1:0]    mask_q, mask_d, pend_q, pend_d;
    logic [NUM_IRQ-1:0] sense_q, sense_d;
    logic [NSRC-1:0]    clr_wr, set_wr, ack_clr, req;
    dphase_t            dph_q, dph_d;
    state_t             state_q, state_d;
    logic [5:0]         ripl_q, ripl_d, vec_q;
    logic               present_q;
    logic               wr_en, win_valid;
    logic [5:0]         win_idx;
    logic [31:0]        rdata;
    logic               unused_bits;

`ifdef MFP_EIC_LITE_CPUINT_EN
    assign src = {SI_SWInt, SI_TimerInt, sync_q[SYNC_STAGES-1]};
`else
    assign src = sync_q[SYNC_STAGES-1];
`endif

    // CPU-side sources have no SENSE bit, so they are always level.
    assign edge_mask = NSRC'(sense_q);

    // AHB address phase; the slave never stalls.
    assign ahb.HREADY = 1'b1;
    assign ahb.HRESP  = 1'b0;

    always_comb begin
        dph_d.valid = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
        dph_d.write = ahb.HWRITE;
        dph_d.addr  = ahb.HADDR[4:2];
    end

    assign wr_en   = dph_q.valid & dph_q.write;
    assign mask_d  = (wr_en && dph_q.addr == REG_MASK)  ? ahb.HWDATA[NSRC-1:0]    : mask_q;
    assign sense_d = (wr_en && dph_q.addr == REG_SENSE) ? ahb.HWDATA[NUM_IRQ-1:0] : sense_q;
    assign clr_wr  = (wr_en && dph_q.addr == REG_CLEAR) ? ahb.HWDATA[NSRC-1:0]    : '0;
    assign set_wr  = (wr_en && dph_q.addr == REG_SET)   ? ahb.HWDATA[NSRC-1:0]    : '0;

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (SI_IAck && SI_IVN == 6'(i + 1)) ack_clr[i] = 1'b1;
        end
    end

    // Edge lines: set beats clear in the same cycle. Level lines simply follow the source.
    assign pend_d = (edge_mask & ((pend_q & ~(ack_clr | clr_wr)) | (src & ~src_dly_q) | set_wr))
                  | (~edge_mask & src);

    assign req = pend_q & mask_q;

    mfp_eic_lite_prio #(.N(NSRC)) u_prio (
        .req_i   (req),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

    always_comb begin
        state_d = state_q;
        ripl_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    ripl_d  = win_idx;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (SI_IAck) begin
                    state_d = ST_HOLD;
                end else if (win_valid) begin
                    ripl_d  = win_idx;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // One blank cycle lets the core raise its IPL before the next request.
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the synchroniser is reset along with everything else so a stale level
    // cannot appear as a fresh edge right after reset release.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sync_q    <= '0;
            src_dly_q <= '0;
            mask_q    <= '0;
            sense_q   <= '0;
            pend_q    <= '0;
            dph_q     <= '0;
            state_q   <= ST_IDLE;
            ripl_q    <= '0;
            vec_q     <= '0;
            present_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            sync_q    <= {sync_q[SYNC_STAGES-2:0], irq};
            src_dly_q <= src;
            mask_q    <= mask_d;
            sense_q   <= sense_d;
            pend_q    <= pend_d;
            dph_q     <= dph_d;
            state_q   <= state_d;
            ripl_q    <= ripl_d;
            vec_q     <= ipl_to_vec(ripl_d);
            present_q <= 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        if (dph_q.valid && !dph_q.write) begin
            case (dph_q.addr)
                REG_MASK:    rdata = 32'(mask_q);
                REG_SENSE:   rdata = 32'(sense_q);
                REG_PENDING: rdata = 32'(pend_q);
                REG_STATUS:  rdata = {16'b0, SI_IPL, 2'b0, ripl_q};
                default:     rdata = '0;
            endcase
        end
    end

    assign ahb.HRDATA    = rdata;
    assign SI_Int        = {2'b0, ripl_q};
    assign SI_EICVector  = vec_q;
    assign SI_EICPresent = present_q;
    assign SI_Offset     = '0;
    assign SI_EISS       = '0;

    assign unused_bits = ^{ahb.HADDR[31:5], ahb.HADDR[1:0], ahb.HTRANS[0], ahb.HWDATA[31:NSRC]};

endmodule

// File: tb/tb_mfp_eic_lite.sv
// Directed self-checking bench for mfp_eic_lite; expected values are hand-derived
// from the cycle timing of the synchroniser, pending logic, FSM and AHB data phase.
module tb_mfp_eic_lite;

    localparam int NUM_IRQ = 8;

    logic               HCLK = 1'b0;
    logic               HRESET = 1'b1;
    logic [NUM_IRQ-1:0] irq = '0;
    logic [7:0]         SI_Int;
    logic [5:0]         SI_EICVector;
    logic               SI_EICPresent;
    logic [16:0]        SI_Offset;
    logic [3:0]         SI_EISS;
    logic               SI_IAck = 1'b0;
    logic [5:0]         SI_IVN = '0;
    logic [7:0]         SI_IPL = '0;
`ifdef MFP_EIC_LITE_CPUINT_EN
    logic               SI_TimerInt = 1'b0;
    logic [1:0]         SI_SWInt = '0;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    mfp_eic_lite_if ahb ();

    mfp_eic_lite #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(2)) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .ahb           (ahb),
        .irq           (irq),
`ifdef MFP_EIC_LITE_CPUINT_EN
        .SI_TimerInt   (SI_TimerInt),
        .SI_SWInt      (SI_SWInt),
`endif
        .SI_Int        (SI_Int),
        .SI_EICVector  (SI_EICVector),
        .SI_EICPresent (SI_EICPresent),
        .SI_Offset     (SI_Offset),
        .SI_EISS       (SI_EISS),
        .SI_IAck       (SI_IAck),
        .SI_IVN        (SI_IVN),
        .SI_IPL        (SI_IPL)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        ahb.HSEL   = 1'b1;
        ahb.HTRANS = 2'b10;
        ahb.HWRITE = 1'b1;
        ahb.HADDR  = addr;
        tick(1);
        ahb.HSEL   = 1'b0;
        ahb.HTRANS = 2'b00;
        ahb.HWRITE = 1'b0;
        ahb.HWDATA = data;
        tick(1);
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        ahb.HSEL   = 1'b1;
        ahb.HTRANS = 2'b10;
        ahb.HWRITE = 1'b0;
        ahb.HADDR  = addr;
        tick(1);
        ahb.HSEL   = 1'b0;
        ahb.HTRANS = 2'b00;
        data = ahb.HRDATA;
    endtask

    initial begin
        ahb.HSEL   = 1'b0;
        ahb.HADDR  = '0;
        ahb.HTRANS = 2'b00;
        ahb.HWRITE = 1'b0;
        ahb.HWDATA = '0;

        // Reset state
        tick(2);
        check("rst_int",     32'(SI_Int),        32'h0);
        check("rst_vec",     32'(SI_EICVector),  32'h0);
        check("rst_present", 32'(SI_EICPresent), 32'h0);
        check("rst_hrdata",  ahb.HRDATA,         32'h0);
        check("hready",      32'(ahb.HREADY),    32'h1);
        check("hresp",       32'(ahb.HRESP),     32'h0);
        check("offset",      32'(SI_Offset),     32'h0);
        check("eiss",        32'(SI_EISS),       32'h0);
        HRESET = 1'b0;
        check("present_rel", 32'(SI_EICPresent), 32'h0);
        tick(1);
        check("present_on",  32'(SI_EICPresent), 32'h1);

        // Level request on irq[3]: 2 sync + 2 cycles to SI_Int
        ahb_write(32'h00, 32'hFF);
        irq = 8'h08;
        tick(3);
        check("lvl_early",   32'(SI_Int),        32'h0);
        tick(1);
        check("lvl_int",     32'(SI_Int),        32'h04);
        check("lvl_vec",     32'(SI_EICVector),  32'h04);
        SI_IPL = 8'h25;
        ahb_read(32'h14, rd);
        check("status",      rd,                 32'h2504);
        irq = 8'h00;
        tick(3);
        check("drop_early",  32'(SI_Int),        32'h04);
        tick(1);
        check("drop_int",    32'(SI_Int),        32'h0);
        check("drop_vec",    32'(SI_EICVector),  32'h0);

        // Edge mode on line 0, single-cycle pulse
        ahb_write(32'h04, 32'h01);
        irq = 8'h01;
        tick(1);
        irq = 8'h00;
        tick(5);
        ahb_read(32'h08, rd);
        check("edge_pend",   rd,                 32'h01);
        check("edge_int",    32'(SI_Int),        32'h01);
        // Out-of-range IVN: HOLD still happens but pend stays
        SI_IAck = 1'b1;
        SI_IVN  = 6'd9;
        tick(1);
        SI_IAck = 1'b0;
        SI_IVN  = 6'd0;
        check("oor_hold",    32'(SI_Int),        32'h0);
        tick(1);
        check("oor_idle",    32'(SI_Int),        32'h0);
        tick(1);
        check("oor_repres",  32'(SI_Int),        32'h01);
        SI_IAck = 1'b1;
        SI_IVN  = 6'd1;
        tick(1);
        SI_IAck = 1'b0;
        SI_IVN  = 6'd0;
        check("ack_hold",    32'(SI_Int),        32'h0);
        check("ack_hold_v",  32'(SI_EICVector),  32'h0);
        ahb_read(32'h08, rd);
        check("ack_pend",    rd,                 32'h0);
        check("ack_int",     32'(SI_Int),        32'h0);

        // Two level sources, then mask the winner
        irq = 8'h44;
        tick(4);
        check("two_vec",     32'(SI_EICVector),  32'h07);
        check("two_int",     32'(SI_Int),        32'h07);
        ahb_write(32'h00, 32'hBF);
        check("mask_same",   32'(SI_EICVector),  32'h07);
        tick(1);
        check("mask_vec",    32'(SI_EICVector),  32'h03);

        // Edge on line 1 coinciding with CLEAR of bit 1: set wins
        ahb_write(32'h04, 32'h12);
        irq = 8'h46;
        tick(1);
        ahb_write(32'h0C, 32'h02);
        ahb_read(32'h08, rd);
        check("set_wins",    rd,                 32'h46);
        ahb_write(32'h0C, 32'h46);
        ahb_read(32'h08, rd);
        check("clear_w1c",   rd,                 32'h44);
        ahb_write(32'h10, 32'h11);
        ahb_read(32'h08, rd);
        check("set_edge",    rd,                 32'h54);
        check("set_vec",     32'(SI_EICVector),  32'h05);
        ahb_write(32'h08, 32'hFF);
        ahb_read(32'h08, rd);
        check("ro_write",    rd,                 32'h54);
        ahb_read(32'h18, rd);
        check("undef_rd",    rd,                 32'h0);
        ahb_read(32'h00, rd);
        check("mask_rd",     rd,                 32'hBF);
        ahb_read(32'h04, rd);
        check("sense_rd",    rd,                 32'h12);
        tick(1);
        check("idle_hrdata", ahb.HRDATA,         32'h0);

        // Reset while presenting
        irq = 8'h00;
        check("pre_rst_int", 32'(SI_Int),        32'h05);
        HRESET = 1'b1;
        #1;
        check("arst_int",     32'(SI_Int),        32'h0);
        check("arst_vec",     32'(SI_EICVector),  32'h0);
        check("arst_present", 32'(SI_EICPresent), 32'h0);
        tick(1);
        HRESET = 1'b0;
        tick(1);
        ahb_read(32'h08, rd);
        check("post_pend",   rd,                 32'h0);
        ahb_read(32'h00, rd);
        check("post_mask",   rd,                 32'h0);
        ahb_read(32'h04, rd);
        check("post_sense",  rd,                 32'h0);
        check("post_present", 32'(SI_EICPresent), 32'h1);

`ifdef MFP_EIC_LITE_CPUINT_EN
        // Timer source sits above every external line
        ahb_write(32'h00, 32'h180);
        SI_TimerInt = 1'b1;
        irq = 8'h80;
        tick(4);
        check("cpu_vec",     32'(SI_EICVector),  32'h09);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mfp_eic_lite.md
Name: mfp_eic_lite

Overview:
Compact External Interrupt Controller (EIC) that sits directly upstream of the MIPS core's EIC interface. It synchronises and latches external IRQ lines and picks the highest-priority unmasked request. It drives the requested IPL and vector into the core, then consumes the core's acknowledge. Software configures it through a small AHB-Lite slave register window on the system matrix.

Parameters:
- NUM_IRQ, 8, number of external IRQ lines; legal range 1..13.
- SYNC_STAGES, 2, synchroniser depth for irq inputs; minimum 2.

Ports:
- HCLK  in  1  system clock; all state on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  AHB slave select.
- HADDR  in  32  AHB address; only [4:2] decoded.
- HTRANS  in  2  AHB transfer type.
- HWRITE  in  1  AHB write.
- HWDATA  in  32  AHB write data.
- HRDATA  out  32  AHB read data.
- HREADY  out  1  always 1; no wait states.
- HRESP  out  1  always 0.
- irq  in  NUM_IRQ  asynchronous external interrupt lines.
- SI_Int  out  8  [5:0] = requested IPL (RIPL), [7:6] = 0.
- SI_EICVector  out  6  requested vector number.
- SI_EICPresent  out  1  constant 1 out of reset.
- SI_Offset  out  17  constant 0.
- SI_EISS  out  4  constant 0.
- SI_IAck  in  1  core acknowledge pulse.
- SI_IVN  in  6  vector being acknowledged.
- SI_IPL  in  8  core's current IPL; used only for status readback.

Behaviour:
- Reset: all registers cleared. Outputs: SI_Int=0, SI_EICVector=0, SI_EICPresent=0 (becomes 1 the first cycle after reset release), HRDATA=0.
- Sync: each irq[i] passes through SYNC_STAGES flops, giving s[i]. Register s_d holds s delayed one cycle for edge detect.
- SENSE[i]=1 (edge): pend[i] sets on s & ~s_d. It clears on an ACK of vector i+1 or a CLEAR write.
- SENSE[i]=0 (level): pend[i] = s[i] every cycle; ACK and CLEAR have no effect.
- Simultaneous set and clear on the same bit in the same cycle: set wins.
- Arbitration: req = pend & MASK. Fixed priority, highest index wins. Winner i gives IPL = vector = i+1; no request gives 0.
- FSM states IDLE, PRESENT, HOLD:
  - IDLE: if req != 0, register RIPL/vector onto SI_Int/SI_EICVector and go to PRESENT. Latency from s edge to SI_Int is 2 HCLK.
  - PRESENT: outputs are re-evaluated every cycle, so a higher source pre-empts in place and a dropped request returns to IDLE with outputs 0. On SI_IAck, go to HOLD.
  - HOLD: drive SI_Int=0 and SI_EICVector=0 for exactly 1 cycle, then return to IDLE. This prevents re-request before the core raises its IPL.
- ACK clear: on SI_IAck, if SI_IVN is in 1..NUM_IRQ and that line is edge-sensed, clear pend[SI_IVN-1]. An out-of-range IVN is ignored.
- AHB: the address phase is captured when HSEL & HTRANS[1] & HREADY. The write takes effect in the data phase. Reads are returned in the data phase from the captured address.
- Register map (offset, access):
  - 0x00 MASK, RW.
  - 0x04 SENSE, RW.
  - 0x08 PENDING, RO.
  - 0x0C CLEAR, WO (write-1-to-clear edge pend).
  - 0x10 SET, WO (write-1-to-set pend, edge lines only).
  - 0x14 STATUS, RO: {SI_IPL[7:0], 2'b0, current RIPL[5:0]}.
  - Unused bits read 0. Writes to RO or undefined offsets are ignored; reads of undefined offsets return 0.
- Reset mid-operation: asynchronous clear of everything; no partial ACK side effects.

Optional Feature:
- Macro MFP_EIC_LITE_CPUINT_EN.
- Defined: adds inputs SI_TimerInt (1) and SI_SWInt (2). They become level sources at indices NUM_IRQ..NUM_IRQ+2, above all external lines, with their own MASK/PENDING bits. They are unsynchronised (already HCLK-domain).
- Undefined: these ports are absent and the register width is NUM_IRQ.

Decomposition:
- Shared package/header mfp_eic_lite.vh holds register offset constants, FSM state encodings, and the IPL-to-vector mapping constant.
- One sub-module, mfp_eic_lite_prio: a combinational, parameterised highest-index priority encoder (req → valid, index+1).

Test Plan:
- Reset, then MASK=0xFF, SENSE=0. Assert irq[3] → SI_Int=4, SI_EICVector=4 two cycles after the synchroniser. Deassert → both 0.
- Edge mode: SENSE=0x01, pulse irq[0] for 1 cycle → PENDING=0x01 held. SI_IAck with SI_IVN=1 → next cycle SI_Int=0 (HOLD), then PENDING=0.
- irq[2] and irq[6] both level-high → vector 7. Mask bit 6 via AHB write MASK=0xBF → vector drops to 3 in the cycle after the write data phase.
- Edge on line 1 coincides with CLEAR write of 0x02 → PENDING bit1 stays 1. SET write 0x10 on an edge line → PENDING bit4 = 1.
- HRESET asserted while in PRESENT → SI_Int, SI_EICVector, SI_EICPresent go to 0 immediately. After release, PENDING=0 and MASK=0.
- With MFP_EIC_LITE_CPUINT_EN: SI_TimerInt=1, MASK bit NUM_IRQ set, irq[7] high → vector NUM_IRQ+1 (=9) wins.
